// File: rtl/pu_or1k_trace_buffer.sv
// OR1K trace-port buffer: filters retired instructions into a small FWFT FIFO.
// Drops on a full FIFO are counted and later emitted in-band as a marker record.
module pu_or1k_trace_buffer #(
    parameter int DEPTH      = 8,
    parameter bit ONLY_JUMPS = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        trace_valid_i,
    input  logic [31:0] trace_pc_i,
    input  logic [31:0] trace_insn_i,
    input  logic        trace_jb_i,
    input  logic [31:0] trace_jbtarget_i,
    input  logic        trace_wben_i,
    input  logic [4:0]  trace_wbreg_i,
    input  logic [31:0] trace_wbdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_type_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_insn_o,
    output logic [31:0] out_jbtarget_o,
    output logic [31:0] out_wbdata_o,
    output logic        out_jb_o,
    output logic        out_wben_o,
    output logic [4:0]  out_wbreg_o,
    output logic [15:0] out_drop_count_o,
    output logic        overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic        typ;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] jbtarget;
        logic [31:0] wbdata;
        logic        jb;
        logic        wben;
        logic [4:0]  wbreg;
        logic [15:0] drop;
    } rec_t;

    rec_t        mem [DEPTH];
    rec_t        wr_rec;
    rec_t        head;
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0] drop_cnt;
    logic        overflow_q;
    logic        cap;
    logic        full;
    logic        pop;
    logic        wr_marker;
    logic        wr_exec;
    logic        wr_en;
    logic        drop;

    assign cap         = trace_valid_i & enable_i & (!ONLY_JUMPS | trace_jb_i);
    assign full        = (count == FULL_CNT);
    assign out_valid_o = (count != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign wr_marker   = (drop_cnt != 16'd0) & !full;
    assign wr_exec     = (drop_cnt == 16'd0) & !full & cap;
    assign wr_en       = wr_marker | wr_exec;
    // A capture coinciding with a marker write has no slot and counts as a drop
    assign drop        = cap & (full | wr_marker);

    always_comb begin
        wr_rec = '0;
        unique case (1'b1)
            wr_marker: begin
                wr_rec.typ  = 1'b1;
                wr_rec.drop = drop_cnt;
            end
            wr_exec: begin
                wr_rec.pc       = trace_pc_i;
                wr_rec.insn     = trace_insn_i;
                wr_rec.jbtarget = trace_jbtarget_i;
                wr_rec.wbdata   = trace_wbdata_i;
                wr_rec.jb       = trace_jb_i;
                wr_rec.wben     = trace_wben_i;
                wr_rec.wbreg    = trace_wbreg_i;
            end
            default: wr_rec = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            if (wr_marker)
                drop_cnt <= {15'd0, cap};
            else if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_rec;
    end

    // Outputs read as zero whenever no record is presented
    assign head             = out_valid_o ? mem[rd_ptr] : '0;
    assign out_type_o       = head.typ;
    assign out_pc_o         = head.pc;
    assign out_insn_o       = head.insn;
    assign out_jbtarget_o   = head.jbtarget;
    assign out_wbdata_o     = head.wbdata;
    assign out_jb_o         = head.jb;
    assign out_wben_o       = head.wben;
    assign out_wbreg_o      = head.wbreg;
    assign out_drop_count_o = head.drop;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_pu_or1k_trace_buffer.sv
// Self-checking bench for pu_or1k_trace_buffer: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pu_or1k_trace_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, valid, jb, wben, ready;
    logic [31:0] pc, insn, jbt, wbdata;
    logic [4:0]  wbreg;

    logic        o_valid, o_type, o_jb, o_wben, o_ovf;
    logic [31:0] o_pc, o_insn, o_jbt, o_wbdata;
    logic [4:0]  o_wbreg;
    logic [15:0] o_drop;

    logic        j_valid, j_type, j_jb, j_wben, j_ovf;
    logic [31:0] j_pc, j_insn, j_jbt, j_wbdata;
    logic [4:0]  j_wbreg;
    logic [15:0] j_drop;

    pu_or1k_trace_buffer #(.DEPTH(4), .ONLY_JUMPS(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .trace_valid_i(valid), .trace_pc_i(pc), .trace_insn_i(insn),
        .trace_jb_i(jb), .trace_jbtarget_i(jbt), .trace_wben_i(wben),
        .trace_wbreg_i(wbreg), .trace_wbdata_i(wbdata),
        .out_valid_o(o_valid), .out_ready_i(ready), .out_type_o(o_type),
        .out_pc_o(o_pc), .out_insn_o(o_insn), .out_jbtarget_o(o_jbt),
        .out_wbdata_o(o_wbdata), .out_jb_o(o_jb), .out_wben_o(o_wben),
        .out_wbreg_o(o_wbreg), .out_drop_count_o(o_drop), .overflow_o(o_ovf)
    );

    pu_or1k_trace_buffer #(.DEPTH(8), .ONLY_JUMPS(1'b1)) dut_jmp (
        .clk_i(clk), .rst_i(rst), .enable_i(enable),
        .trace_valid_i(valid), .trace_pc_i(pc), .trace_insn_i(insn),
        .trace_jb_i(jb), .trace_jbtarget_i(jbt), .trace_wben_i(wben),
        .trace_wbreg_i(wbreg), .trace_wbdata_i(wbdata),
        .out_valid_o(j_valid), .out_ready_i(ready), .out_type_o(j_type),
        .out_pc_o(j_pc), .out_insn_o(j_insn), .out_jbtarget_o(j_jbt),
        .out_wbdata_o(j_wbdata), .out_jb_o(j_jb), .out_wben_o(j_wben),
        .out_wbreg_o(j_wbreg), .out_drop_count_o(j_drop), .overflow_o(j_ovf)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rdy;
        logic        v;
        logic [31:0] p;
        logic        ev;
        logic        et;
        logic [31:0] ep;
        logic [15:0] ed;
        logic        eo;
    } vec_t;
    vec_t tbl[14];

    typedef struct {
        logic        t;
        logic [31:0] pc, insn, jbt, wbdata;
        logic        jb, wben;
        logic [4:0]  wbreg;
        logic [15:0] d;
    } mrec_t;
    mrec_t q[$];
    mrec_t r;
    int          mdrop;
    logic        movf, mcap, mfull, mpop;
    int          rdy_pct;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic j);
        valid  = v;
        pc     = p;
        insn   = p ^ 32'h1500_0000;
        jb     = j;
        jbt    = p + 32'h40;
        wben   = p[0];
        wbreg  = p[4:0];
        wbdata = ~p;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ready  = 1'b0;
        enable = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_rec(input string name, input logic et,
                              input logic [31:0] ep, input logic [15:0] ed);
        int k;
        k = 0;
        ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        while (!o_valid && k < 20) begin
            tick();
            k++;
        end
        check({name, "_valid"}, 64'(o_valid), 64'd1);
        if (o_valid) begin
            check({name, "_type"}, 64'(o_type), 64'(et));
            check({name, "_drop"}, 64'(o_drop), 64'(ed));
            if (!et) begin
                check({name, "_pc"}, 64'(o_pc), 64'(ep));
                check({name, "_insn"}, 64'(o_insn), 64'(ep ^ 32'h1500_0000));
            end
        end
        tick();
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   16'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   16'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h1,   1'b1, 1'b0, 32'h0,   16'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h2,   1'b1, 1'b0, 32'h0,   16'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h3,   1'b1, 1'b0, 32'h0,   16'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h4,   1'b1, 1'b0, 32'h0,   16'd0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h5,   1'b1, 1'b0, 32'h0,   16'd0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h1,   16'd0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h2,   16'd0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h3,   16'd0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   16'd2, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   16'd0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   16'd0, 1'b1};

        do_reset();
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_ovf", 64'(o_ovf), 64'd0);
        check("reset_pc", 64'(o_pc), 64'd0);

        // Single event, then DEPTH=4 overflow with a 2-drop marker
        for (int i = 0; i < 14; i++) begin
            ready = tbl[i].rdy;
            drive(tbl[i].v, tbl[i].p, 1'b0);
            tick();
            check("tbl_valid", 64'(o_valid), 64'(tbl[i].ev));
            check("tbl_ovf", 64'(o_ovf), 64'(tbl[i].eo));
            if (tbl[i].ev) begin
                check("tbl_type", 64'(o_type), 64'(tbl[i].et));
                check("tbl_pc", 64'(o_pc), 64'(tbl[i].ep));
                check("tbl_drop", 64'(o_drop), 64'(tbl[i].ed));
            end
        end

        // Capture dropped in the same cycle a pending marker is written
        do_reset();
        fill(32'h10, 4);
        fill(32'h20, 3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        drive(1'b1, 32'h99, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        expect_rec("mk_r11", 1'b0, 32'h11, 16'd0);
        expect_rec("mk_r12", 1'b0, 32'h12, 16'd0);
        expect_rec("mk_r13", 1'b0, 32'h13, 16'd0);
        expect_rec("mk_m3", 1'b1, 32'h0, 16'd3);
        expect_rec("mk_m1", 1'b1, 32'h0, 16'd1);
        tick();
        check("mk_empty", 64'(o_valid), 64'd0);

        // Drop counter saturation
        do_reset();
        fill(32'h40, 4);
        drive(1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 70000; i++) tick();
        drive(1'b0, 32'h0, 1'b0);
        check("sat_ovf", 64'(o_ovf), 64'd1);
        for (int i = 0; i < 4; i++)
            expect_rec("sat_rec", 1'b0, 32'h40 + 32'(i), 16'd0);
        expect_rec("sat_marker", 1'b1, 32'h0, 16'hFFFF);
        tick();
        check("sat_empty", 64'(o_valid), 64'd0);

        // enable_i low: no capture, no drop, queue still drains
        do_reset();
        fill(32'h50, 4);
        enable = 1'b0;
        fill(32'h58, 6);
        check("en_ovf", 64'(o_ovf), 64'd0);
        for (int i = 0; i < 4; i++)
            expect_rec("en_rec", 1'b0, 32'h50 + 32'(i), 16'd0);
        tick();
        check("en_empty", 64'(o_valid), 64'd0);
        enable = 1'b1;

        // Reset with queued records and a pending marker
        do_reset();
        fill(32'h60, 6);
        ready = 1'b1;
        tick();
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        check("rst_drop", 64'(o_drop), 64'd0);
        ready = 1'b1;
        drive(1'b1, 32'h300, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        check("rst_new_valid", 64'(o_valid), 64'd1);
        check("rst_new_type", 64'(o_type), 64'd0);
        check("rst_new_pc", 64'(o_pc), 64'h300);
        tick();
        check("rst_new_gone", 64'(o_valid), 64'd0);
        tick();
        check("rst_no_marker", 64'(o_valid), 64'd0);

        // ONLY_JUMPS filter on the second instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(i), (i == 0) || (i == 3));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        ready = 1'b1;
        check("jmp_v0", 64'(j_valid), 64'd1);
        check("jmp_pc0", 64'(j_pc), 64'h200);
        check("jmp_jb0", 64'(j_jb), 64'd1);
        tick();
        check("jmp_v1", 64'(j_valid), 64'd1);
        check("jmp_pc1", 64'(j_pc), 64'h203);
        tick();
        check("jmp_empty", 64'(j_valid), 64'd0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h280 + 32'(i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        check("jmp_dis_valid", 64'(j_valid), 64'd0);
        check("jmp_dis_ovf", 64'(j_ovf), 64'd0);
        enable = 1'b1;

        // Randomized traffic against the queue model
        do_reset();
        q.delete();
        mdrop   = 0;
        movf    = 1'b0;
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            check("rnd_valid", 64'(o_valid), 64'(q.size() != 0));
            check("rnd_ovf", 64'(o_ovf), 64'(movf));
            if (q.size() != 0) begin
                check("rnd_type", 64'(o_type), 64'(q[0].t));
                check("rnd_drop", 64'(o_drop), 64'(q[0].d));
                if (!q[0].t) begin
                    check("rnd_pc_insn", {o_pc, o_insn}, {q[0].pc, q[0].insn});
                    check("rnd_jbt_wbd", {o_jbt, o_wbdata}, {q[0].jbt, q[0].wbdata});
                    check("rnd_flags", {o_jb, o_wben, o_wbreg},
                          {q[0].jb, q[0].wben, q[0].wbreg});
                end
            end
            if (n % 200 == 0) rdy_pct = $urandom_range(5, 95);
            ready  = ($urandom_range(0, 99) < rdy_pct);
            valid  = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 9) != 0);
            jb     = 1'($urandom);
            pc     = $urandom;
            insn   = $urandom;
            jbt    = $urandom;
            wbdata = $urandom;
            wben   = 1'($urandom);
            wbreg  = 5'($urandom);
            mcap  = valid & enable;
            mfull = (q.size() == 4);
            mpop  = (q.size() != 0) && ready;
            if (mdrop != 0 && !mfull) begin
                r = '{1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'h0, 16'(mdrop)};
                q.push_back(r);
                mdrop = mcap ? 1 : 0;
                if (mcap) movf = 1'b1;
            end else if (!mfull && mcap) begin
                r = '{1'b0, pc, insn, jbt, wbdata, jb, wben, wbreg, 16'h0};
                q.push_back(r);
            end else if (mcap) begin
                mdrop = (mdrop < 65535) ? mdrop + 1 : 65535;
                movf  = 1'b1;
            end
            if (mpop) void'(q.pop_front());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
